exec_core_seq: RTL and testbench
================================

EXEC_CORE_SEQ -- requirements
Module: exec_core_seq

Interface
REQ-001 Parameter N, default 16, data width of registers, operands and results.
REQ-002 Parameter NREG, default 16, number of architectural registers; SEL = clog2(NREG).
REQ-003 Parameter X0_ZERO, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 instr_valid  input  1  instruction offered this cycle.
REQ-007 instr_ready  output  1  core can accept an instruction this cycle.
REQ-008 opcode  input  4  0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 li, 8 rem, 9-15 illegal.
REQ-009 rd_sel / rs1_sel / rs2_sel  input  SEL each  destination and source register indices.
REQ-010 imm_val  input  N  immediate for li.
REQ-011 wb_valid  output  1  one-cycle pulse: an instruction retired.
REQ-012 wb_rd  output  SEL  destination of retired instruction.
REQ-013 wb_data  output  N  result of retired instruction (truncated to N bits).
REQ-014 exc_ovf  output  1  with wb_valid: add carry-out, sub borrow, or mul upper half non-zero.
REQ-015 exc_dz  output  1  with wb_valid: div/rem with divisor 0.
REQ-016 exc_ill  output  1  with wb_valid: illegal opcode.
REQ-017 dbg_sel  input  SEL; dbg_data  output  N  combinational register-file read port.
REQ-018 retire_cnt  output  32  count of wb_valid pulses since reset.

Function
REQ-019 Accept occurs on a rising edge where instr_valid && instr_ready; sources read from the register file at that edge.
REQ-020 States: IDLE, MUL, DIV; instr_ready = 1 only in IDLE.
REQ-021 add, sub, and, or, xor, li, illegal, and div/rem with divisor 0: retire on the accept edge; latency 1 (wb_valid high the cycle after accept); state stays IDLE.
REQ-022 mul with non-zero operands or otherwise: IDLE->MUL; shift-add, one bit per cycle; retires on the N-th edge after accept; MUL->IDLE on that edge.
REQ-023 div/rem with divisor != 0: IDLE->DIV; restoring division, one quotient bit per cycle; retires on the N-th edge after accept; DIV->IDLE on that edge.
REQ-024 div writes quotient; rem writes remainder; unsigned operands.
REQ-025 Divisor 0: div result all ones, rem result = rs1 value, exc_dz = 1, register written.
REQ-026 Overflow (exc_ovf): result still written, truncated to low N bits; sub borrow when rs1 < rs2.
REQ-027 li: rd <= imm_val; rs1/rs2 ignored; exc flags 0.
REQ-028 Illegal opcode: no register written, wb_rd = rd_sel, wb_data = 0, exc_ill = 1.
REQ-029 Register write and wb_* update occur on the same retire edge; an instruction accepted the next cycle sees the new value (no forwarding hazard).
REQ-030 X0_ZERO=1 and rd=0: write suppressed, wb_data still reports computed result.
REQ-031 Exception flags are 0 whenever wb_valid is 0.
REQ-032 retire_cnt increments by 1 per wb_valid pulse, wraps 0xFFFFFFFF -> 0.
REQ-033 instr_valid while not ready is ignored; it is not queued.

Reset
REQ-034 rst low asynchronously: state IDLE, all registers 0, wb_valid/exc_* 0, wb_rd/wb_data 0, retire_cnt 0, instr_ready 1 once rst high.
REQ-035 Reset during MUL/DIV aborts the operation; no write-back occurs for it.

Verification
REQ-036 li x3,40; li x4,25; add x5,x4,x3 -> wb_data 65 at cycle after accept, exc_ovf 0, dbg_sel=5 reads 65.
REQ-037 x1=0xFFFF, x2=2, add x6,x2,x1 -> wb_data 0x0001, exc_ovf 1; sub x7,x2,x1 -> 0x0003, exc_ovf 1.
REQ-038 x1=300, x2=300, mul x8,x2,x1 -> instr_ready 0 for 16 cycles, wb_data 0x5F90, exc_ovf 1, retire after exactly 16 edges.
REQ-039 x1=50, x2=7: div -> 7, rem -> 1, each 16-cycle latency; divisor x0 -> div 0xFFFF, rem 50, exc_dz 1, latency 1.
REQ-040 opcode 12 -> exc_ill 1, no register changes; li x0,9 -> dbg x0 reads 0.
REQ-041 rst low at cycle 5 of mul -> no wb_valid, all registers 0, retire_cnt 0, next li accepted normally.

Source files
------------

// File: rtl/exec_core_seq_if.sv
// Instruction issue / write-back bundle between an instruction source and exec_core_seq.
interface exec_core_seq_if #(
  parameter int unsigned N   = 16,
  parameter int unsigned SEL = 4
);
  logic           instr_valid;
  logic           instr_ready;
  logic [3:0]     opcode;
  logic [SEL-1:0] rd_sel;
  logic [SEL-1:0] rs1_sel;
  logic [SEL-1:0] rs2_sel;
  logic [N-1:0]   imm_val;
  logic           wb_valid;
  logic [SEL-1:0] wb_rd;
  logic [N-1:0]   wb_data;
  logic           exc_ovf;
  logic           exc_dz;
  logic           exc_ill;

  modport master (
    output instr_valid, opcode, rd_sel, rs1_sel, rs2_sel, imm_val,
    input  instr_ready, wb_valid, wb_rd, wb_data, exc_ovf, exc_dz, exc_ill
  );

  modport slave (
    input  instr_valid, opcode, rd_sel, rs1_sel, rs2_sel, imm_val,
    output instr_ready, wb_valid, wb_rd, wb_data, exc_ovf, exc_dz, exc_ill
  );
endinterface

// File: rtl/exec_core_seq.sv
// Sequential execution core: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide, with a register file, one-cycle write-back pulse and retire counter.
module exec_core_seq #(
  parameter int unsigned  N       = 16,
  parameter int unsigned  NREG    = 16,
  parameter bit           X0_ZERO = 1'b1,
  localparam int unsigned SEL     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic           clk,
  input  logic           rst,
  exec_core_seq_if.slave bus,
  input  logic [SEL-1:0] dbg_sel,
  output logic [N-1:0]   dbg_data,
  output logic [31:0]    retire_cnt
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpLi  = 4'd7;
  localparam logic [3:0] OpRem = 4'd8;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      regs_q [NREG];
  logic [2*N-1:0]    acc_q, acc_d;
  logic [2*N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]      mplier_q, mplier_d;
  logic [N-1:0]      rem_q, rem_d;
  logic [N-1:0]      quo_q, quo_d;
  logic [N-1:0]      dvsr_q, dvsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SEL-1:0]    rd_q, rd_d;
  logic              is_rem_q, is_rem_d;

  logic              wb_valid_q, wb_valid_d;
  logic [SEL-1:0]    wb_rd_q, wb_rd_d;
  logic [N-1:0]      wb_data_q, wb_data_d;
  logic              exc_ovf_q, exc_ovf_d;
  logic              exc_dz_q, exc_dz_d;
  logic              exc_ill_q, exc_ill_d;
  logic [31:0]       retire_cnt_q;

  logic [N-1:0]      rs1_val, rs2_val;
  logic [N:0]        add_sum;
  logic [2*N-1:0]    mul_acc;
  logic [N:0]        rem_shift, rem_diff;
  logic              quo_bit;

  logic              ret, ret_we, ret_ovf, ret_dz, ret_ill;
  logic [SEL-1:0]    ret_rd;
  logic [N-1:0]      ret_data;
  logic              rf_we;

  // Register 0 is hard-wired to zero when X0_ZERO is set.
  assign rs1_val  = (X0_ZERO && bus.rs1_sel == '0) ? '0 : regs_q[bus.rs1_sel];
  assign rs2_val  = (X0_ZERO && bus.rs2_sel == '0) ? '0 : regs_q[bus.rs2_sel];
  assign dbg_data = (X0_ZERO && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

  assign add_sum  = {1'b0, rs1_val} + {1'b0, rs2_val};
  assign mul_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Restoring step: bit N of the difference is the borrow, i.e. the trial subtract failed.
  assign rem_shift = {rem_q, quo_q[N-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign quo_bit   = ~rem_diff[N];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    is_rem_d = is_rem_q;
    ret      = 1'b0;
    ret_we   = 1'b0;
    ret_rd   = rd_q;
    ret_data = '0;
    ret_ovf  = 1'b0;
    ret_dz   = 1'b0;
    ret_ill  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          ret    = 1'b1;
          ret_we = 1'b1;
          ret_rd = bus.rd_sel;
          case (bus.opcode)
            OpAdd: begin
              ret_data = add_sum[N-1:0];
              ret_ovf  = add_sum[N];
            end
            OpSub: begin
              ret_data = rs1_val - rs2_val;
              ret_ovf  = (rs1_val < rs2_val);
            end
            OpMul: begin
              ret      = 1'b0;
              state_d  = StMul;
              acc_d    = '0;
              mcand_d  = {{N{1'b0}}, rs1_val};
              mplier_d = rs2_val;
              cnt_d    = '0;
              rd_d     = bus.rd_sel;
            end
            OpDiv, OpRem: begin
              if (rs2_val == '0) begin
                ret_dz   = 1'b1;
                ret_data = (bus.opcode == OpRem) ? rs1_val : '1;
              end else begin
                ret      = 1'b0;
                state_d  = StDiv;
                rem_d    = '0;
                quo_d    = rs1_val;
                dvsr_d   = rs2_val;
                cnt_d    = '0;
                rd_d     = bus.rd_sel;
                is_rem_d = (bus.opcode == OpRem);
              end
            end
            OpAnd:   ret_data = rs1_val & rs2_val;
            OpOr:    ret_data = rs1_val | rs2_val;
            OpXor:   ret_data = rs1_val ^ rs2_val;
            OpLi:    ret_data = bus.imm_val;
            default: begin
              ret_we  = 1'b0;
              ret_ill = 1'b1;
            end
          endcase
        end
      end
      StMul: begin
        acc_d    = mul_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          ret      = 1'b1;
          ret_we   = 1'b1;
          ret_data = mul_acc[N-1:0];
          ret_ovf  = |mul_acc[2*N-1:N];
          state_d  = StIdle;
        end
      end
      StDiv: begin
        rem_d = quo_bit ? rem_diff[N-1:0] : rem_shift[N-1:0];
        quo_d = {quo_q[N-2:0], quo_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          ret      = 1'b1;
          ret_we   = 1'b1;
          ret_data = is_rem_q ? rem_d : quo_d;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    wb_valid_d = ret;
    wb_rd_d    = ret ? ret_rd : wb_rd_q;
    wb_data_d  = ret ? ret_data : wb_data_q;
    exc_ovf_d  = ret & ret_ovf;
    exc_dz_d   = ret & ret_dz;
    exc_ill_d  = ret & ret_ill;
    // wb_data still reports the result even when the x0 write is dropped.
    rf_we      = ret & ret_we & ~(X0_ZERO && ret_rd == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      cnt_q        <= '0;
      rd_q         <= '0;
      is_rem_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      exc_ovf_q    <= 1'b0;
      exc_dz_q     <= 1'b0;
      exc_ill_q    <= 1'b0;
      retire_cnt_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      is_rem_q     <= is_rem_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      exc_ovf_q    <= exc_ovf_d;
      exc_dz_q     <= exc_dz_d;
      exc_ill_q    <= exc_ill_d;
      retire_cnt_q <= retire_cnt_q + 32'(wb_valid_d);
      if (rf_we) begin
        regs_q[ret_rd] <= ret_data;
      end
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.exc_ovf     = exc_ovf_q;
  assign bus.exc_dz      = exc_dz_q;
  assign bus.exc_ill     = exc_ill_q;
  assign retire_cnt      = retire_cnt_q;

endmodule

// File: tb/tb_exec_core_seq.sv
// Scoreboard bench for exec_core_seq: a reference register model predicts each retirement,
// a negedge monitor pops and compares; scenario tasks check latency, debug reads and reset.
module tb_exec_core_seq;
  localparam int unsigned N    = 16;
  localparam int unsigned NREG = 16;
  localparam int unsigned SEL  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [SEL-1:0] dbg_sel;
  logic [N-1:0]   dbg_data;
  logic [31:0]    retire_cnt;

  always #5 clk = ~clk;

  exec_core_seq_if #(.N(N), .SEL(SEL)) bus ();

  exec_core_seq #(.N(N), .NREG(NREG), .X0_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .retire_cnt (retire_cnt)
  );

  typedef struct {
    logic [SEL-1:0] rd;
    logic [N-1:0]   data;
    logic           ovf;
    logic           dz;
    logic           ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [N-1:0] mregs[NREG];
  logic [31:0] exp_cnt;
  int          n_chk  = 0;
  int          n_fail = 0;

  // Retirement monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_cnt = '0;
    end else begin
      n_chk++;
      if (bus.wb_valid) begin
        exp_cnt = exp_cnt + 1;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h, required no retirement",
                   bus.wb_rd, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.exc_ovf, bus.exc_dz, bus.exc_ill} !==
              {e.rd, e.data, e.ovf, e.dz, e.ill}) begin
            n_fail++;
            $display("FAIL wb_result: got rd=%0d data=%h ovf=%b dz=%b ill=%b, required rd=%0d data=%h ovf=%b dz=%b ill=%b",
                     bus.wb_rd, bus.wb_data, bus.exc_ovf, bus.exc_dz, bus.exc_ill,
                     e.rd, e.data, e.ovf, e.dz, e.ill);
          end
        end
        n_chk++;
        if (retire_cnt !== exp_cnt) begin
          n_fail++;
          $display("FAIL retire_cnt: got %0d, required %0d", retire_cnt, exp_cnt);
        end
      end else if ({bus.exc_ovf, bus.exc_dz, bus.exc_ill} !== 3'b000) begin
        n_fail++;
        $display("FAIL exc_idle: got ovf=%b dz=%b ill=%b, required all 0",
                 bus.exc_ovf, bus.exc_dz, bus.exc_ill);
      end
    end
  end

  // Predict, drive one instruction, and check retire edge and busy cycles.
  task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                       input logic [N-1:0] imm, input bit hold);
    exp_t           e;
    logic [N:0]     s;
    logic [2*N-1:0] p;
    logic [N-1:0]   a, b;
    int             k, busy, exp_lat;
    bit             long_op;
    a = mregs[rs1];
    b = mregs[rs2];
    e.rd = SEL'(rd); e.data = '0; e.ovf = 1'b0; e.dz = 1'b0; e.ill = 1'b0;
    long_op = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.data = s[N-1:0]; e.ovf = s[N]; end
      4'd1: begin e.data = a - b; e.ovf = (a < b); end
      4'd2: begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        e.data = p[N-1:0]; e.ovf = (p[2*N-1:N] != '0); long_op = 1'b1;
      end
      4'd3: if (b == '0) begin e.data = '1; e.dz = 1'b1; end
            else begin e.data = a / b; long_op = 1'b1; end
      4'd4: e.data = a & b;
      4'd5: e.data = a | b;
      4'd6: e.data = a ^ b;
      4'd7: e.data = imm;
      4'd8: if (b == '0) begin e.data = a; e.dz = 1'b1; end
            else begin e.data = a % b; long_op = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    exp_q.push_back(e);
    if (!e.ill && rd != 0) mregs[rd] = e.data;

    @(negedge clk);
    k = 0;
    while (!bus.instr_ready && k < 40) begin @(negedge clk); k++; end
    n_chk++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: got instr_ready=%b, required 1", bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.opcode  = op;
    bus.rd_sel  = SEL'(rd);
    bus.rs1_sel = SEL'(rs1);
    bus.rs2_sel = SEL'(rs2);
    bus.imm_val = imm;
    @(posedge clk);
    #1;
    if (hold) begin
      // Offered while busy: must be dropped, not queued.
      bus.opcode  = 4'd7;
      bus.rd_sel  = SEL'(9);
      bus.imm_val = 16'hBEEF;
    end else begin
      bus.instr_valid = 1'b0;
    end
    k = 0;
    busy = 0;
    while (!bus.wb_valid && k < 40) begin
      if (!bus.instr_ready) busy++;
      @(posedge clk);
      #1;
      k++;
    end
    bus.instr_valid = 1'b0;
    exp_lat = long_op ? N : 0;
    n_chk++;
    if (k !== exp_lat) begin
      n_fail++;
      $display("FAIL retire_edge op=%0d: got %0d edges after accept, required %0d", op, k, exp_lat);
    end
    n_chk++;
    if (busy !== exp_lat) begin
      n_fail++;
      $display("FAIL busy_cycles op=%0d: got %0d, required %0d", op, busy, exp_lat);
    end
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.opcode = '0; bus.rd_sel = '0; bus.rs1_sel = '0; bus.rs2_sel = '0; bus.imm_val = '0;
    dbg_sel = '0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.wb_valid, bus.exc_ovf, bus.exc_dz, bus.exc_ill, bus.wb_rd, bus.wb_data, retire_cnt}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wb_valid=%b rd=%0d data=%h cnt=%0d, required all 0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, retire_cnt);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", bus.instr_ready);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = SEL'(i);
      #1;
      n_chk++;
      if (dbg_data !== '0) begin
        n_fail++;
        $display("FAIL reset_reg x%0d: got %h, required 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_alu();
    issue(4'd7, 3, 0, 0, 16'd40, 1'b0);
    issue(4'd7, 4, 0, 0, 16'd25, 1'b0);
    issue(4'd0, 5, 4, 3, 16'd0, 1'b0);
    dbg_sel = SEL'(5);
    #1;
    n_chk++;
    if (dbg_data !== 16'd65) begin
      n_fail++;
      $display("FAIL add_dbg x5: got %0d, required 65", dbg_data);
    end
    issue(4'd7, 10, 0, 0, 16'hA5C3, 1'b0);
    issue(4'd7, 11, 0, 0, 16'h0FF0, 1'b0);
    issue(4'd4, 12, 10, 11, 16'd0, 1'b0);
    issue(4'd5, 13, 10, 11, 16'd0, 1'b0);
    issue(4'd6, 14, 10, 11, 16'd0, 1'b0);
    issue(4'd1, 15, 10, 11, 16'd0, 1'b0);
  endtask

  task automatic test_overflow();
    issue(4'd7, 1, 0, 0, 16'hFFFF, 1'b0);
    issue(4'd7, 2, 0, 0, 16'd2, 1'b0);
    issue(4'd0, 6, 2, 1, 16'd0, 1'b0);
    issue(4'd1, 7, 2, 1, 16'd0, 1'b0);
    dbg_sel = SEL'(6);
    #1;
    n_chk++;
    if (dbg_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL add_ovf x6: got %h, required 0001", dbg_data);
    end
    dbg_sel = SEL'(7);
    #1;
    n_chk++;
    if (dbg_data !== 16'h0003) begin
      n_fail++;
      $display("FAIL sub_borrow x7: got %h, required 0003", dbg_data);
    end
  endtask

  task automatic test_mul();
    issue(4'd7, 1, 0, 0, 16'd300, 1'b0);
    issue(4'd7, 2, 0, 0, 16'd300, 1'b0);
    issue(4'd2, 8, 2, 1, 16'd0, 1'b1);
    dbg_sel = SEL'(8);
    #1;
    n_chk++;
    if (dbg_data !== 16'h5F90) begin
      n_fail++;
      $display("FAIL mul x8: got %h, required 5F90", dbg_data);
    end
    dbg_sel = SEL'(9);
    #1;
    n_chk++;
    if (dbg_data !== mregs[9]) begin
      n_fail++;
      $display("FAIL busy_ignored x9: got %h, required %h", dbg_data, mregs[9]);
    end
  endtask

  task automatic test_div();
    logic [N-1:0] want [4];
    want[0] = 16'd7; want[1] = 16'd1; want[2] = 16'hFFFF; want[3] = 16'd50;
    issue(4'd7, 1, 0, 0, 16'd50, 1'b0);
    issue(4'd7, 2, 0, 0, 16'd7, 1'b0);
    issue(4'd3, 9, 1, 2, 16'd0, 1'b1);
    issue(4'd8, 10, 1, 2, 16'd0, 1'b0);
    issue(4'd3, 11, 1, 0, 16'd0, 1'b0);
    issue(4'd8, 12, 1, 0, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = SEL'(9 + i);
      #1;
      n_chk++;
      if (dbg_data !== want[i]) begin
        n_fail++;
        $display("FAIL div_rem x%0d: got %h, required %h", 9 + i, dbg_data, want[i]);
      end
    end
  endtask

  task automatic test_illegal_x0();
    issue(4'd12, 5, 1, 2, 16'd0, 1'b0);
    issue(4'd7, 0, 0, 0, 16'd9, 1'b0);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = SEL'(i);
      #1;
      n_chk++;
      if (dbg_data !== mregs[i]) begin
        n_fail++;
        $display("FAIL illegal_regs x%0d: got %h, required %h", i, dbg_data, mregs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 1; i < NREG; i++) issue(4'd7, i, 0, 0, N'($urandom), 1'b0);
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 9));
      if (op == 4'd9) op = 4'd13;
      issue(op, int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
            int'($urandom_range(0, NREG - 1)), N'($urandom), 1'($urandom));
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = SEL'(i);
      #1;
      n_chk++;
      if (dbg_data !== mregs[i]) begin
        n_fail++;
        $display("FAIL b2b_regs x%0d: got %h, required %h", i, dbg_data, mregs[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    issue(4'd7, 1, 0, 0, 16'd300, 1'b0);
    issue(4'd7, 2, 0, 0, 16'd7, 1'b0);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.opcode = 4'd2; bus.rd_sel = SEL'(8); bus.rs1_sel = SEL'(1); bus.rs2_sel = SEL'(2);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    #1;
    n_chk++;
    if ({bus.wb_valid, retire_cnt} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got wb_valid=%b cnt=%0d, required 0", bus.wb_valid, retire_cnt);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = SEL'(i);
      #1;
      n_chk++;
      if (dbg_data !== '0) begin
        n_fail++;
        $display("FAIL abort_reg x%0d: got %h, required 0", i, dbg_data);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(4'd7, 3, 0, 0, 16'h1234, 1'b0);
    dbg_sel = SEL'(3);
    #1;
    n_chk++;
    if (dbg_data !== 16'h1234 || retire_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL after_abort: got x3=%h cnt=%0d, required 1234 and 1", dbg_data, retire_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_overflow();
    test_mul();
    test_div();
    test_illegal_x0();
    test_back_to_back();
    test_reset_mid_mul();
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: got %0d unretired predictions, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
